// File: rtl/repsub_divider.sv
// Unsigned repeated-subtraction divider: loads the dividend, then the divisor, from a shared bus.
// It subtracts the divisor once per clock and counts the subtractions into the quotient.
module repsub_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CHECK,
    S_SUB,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dbz_q, dbz_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      d_q     <= d_d;
      q_q     <= q_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    d_d     = d_q;
    q_d     = q_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        r_d     = datain;
        dbz_d   = 1'b0;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        d_d     = datain;
        q_d     = '0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // A zero divisor leaves R holding the dividend and saturates Q.
        if (d_q == '0) begin
          dbz_d   = 1'b1;
          q_d     = '1;
          state_d = S_DONE;
        end else begin
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        if (r_q >= d_q) begin
          r_d = r_q - d_q;
          q_d = q_q + WIDTH'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) state_d = S_LOAD_A;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) ||
                     (state_q == S_CHECK)  || (state_q == S_SUB);
  assign done      = (state_q == S_DONE);
  assign quotient  = q_q;
  assign remainder = r_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_repsub_divider.sv
// Scoreboard bench for repsub_divider: the driver queues hand-computed results,
// and a monitor checks each rising edge of done against the queue.
module tb_repsub_divider;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] datain;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             dbz;

  repsub_divider #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .datain    (datain),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz)
  );

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    int               lat;
    int               e0;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   sim_end = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one scoreboard entry consumed per rising edge of done.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    while (!sim_end) begin
      @(negedge clk);
      if (rst_n && done && !prev_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("quotient",  quotient,  e.q);
          check("remainder", remainder, e.r);
          check("dbz",       dbz,       e.dbz);
          check("latency",   cyc - e.e0, e.lat);
        end
      end
      prev_done = done;
    end
  end

  // Called just after a negedge; the next rising edge is E0.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                       input logic edbz, input int elat, input bit hold, input bit push);
    exp_t e;
    start  = 1'b1;
    datain = a;
    if (push) begin
      e.q = eq; e.r = er; e.dbz = edbz; e.lat = elat; e.e0 = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    check("busy_done_after_E0", {busy, done}, 2'b10);
    if (!hold) start = 1'b0;
    @(negedge clk);
    datain = b;
    @(negedge clk);
    datain = WIDTH'($urandom);
  endtask

  task automatic wait_done(input int limit, input bit pulse);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
      datain = WIDTH'($urandom);
      if (pulse) start = (n < 200) ? n[0] : 1'b0;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic idle_gap();
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    datain = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {quotient, remainder, busy, done, dbz}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {busy, done}, 2'b00);

    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 18, 1'b0, 1'b1);
    wait_done(100, 1'b0);
    idle_gap();

    issue(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 4, 1'b0, 1'b1);
    wait_done(100, 1'b0);
    idle_gap();
    issue(16'd0, 16'd3, 16'd0, 16'd0, 1'b0, 4, 1'b0, 1'b1);
    wait_done(100, 1'b0);
    idle_gap();

    issue(16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 3, 1'b0, 1'b1);
    wait_done(100, 1'b0);
    idle_gap();
    issue(16'd20, 16'd4, 16'd5, 16'd0, 1'b0, 9, 1'b0, 1'b1);
    wait_done(100, 1'b0);
    idle_gap();

    issue(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 65539, 1'b0, 1'b1);
    wait_done(70000, 1'b1);
    idle_gap();

    // Abort mid-SUB: nothing queued for this run.
    issue(16'd1000, 16'd3, '0, '0, 1'b0, 0, 1'b0, 1'b0);
    repeat (50) @(negedge clk);
    check("busy_mid_sub", {busy, done}, 2'b10);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {quotient, remainder, busy, done, dbz}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 337, 1'b0, 1'b1);
    wait_done(500, 1'b0);
    idle_gap();

    issue(16'd9, 16'd2, 16'd4, 16'd1, 1'b0, 8, 1'b1, 1'b1);
    wait_done(100, 1'b0);
    check("start_held_in_done", start, 1'b1);
    issue(16'd50, 16'd6, 16'd8, 16'd2, 1'b0, 12, 1'b0, 1'b1);
    wait_done(100, 1'b0);
    idle_gap();

    check("scoreboard_empty", sb.size(), 0);
    sim_end = 1'b1;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
